systolic_feed_ctrl: RTL

Sequences one matrix-multiply pass through the ARRAY_DIM x ARRAY_DIM systolic array. On `start` it issues K read addresses to the operand buffers and generates per-row skewed feed enables, so row r enters the array r cycles after row 0. It then waits for the array to drain, clears accumulators at the start of the pass, and pulses `done`. It sits between the top-level command logic and the operand buffers/PE array, and replaces hand-wired skew delays on the control path.

---
 rtl/tpu_ctrl_pkg.sv | 21 ++
 rtl/systolic_feed_ctrl_if.sv | 35 +++
 rtl/skew_shift.sv | 27 ++
 rtl/systolic_feed_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared control-path types for the systolic array sequencers.
// Holds the feed FSM state encoding and drain-length helpers.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_e;

    // Cycles for the last operand to ripple out of an dim x dim array.
    function automatic int drain_len(input int dim);
        return 2 * dim - 1;
    endfunction

    function automatic int drain_cnt_w(input int dim);
        return $clog2(2 * dim) + 1;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Command/feed bundle between the pass sequencer, command logic and PE array.
// The controller takes the slave view; the command side takes the master view.
interface systolic_feed_ctrl_if #(
    parameter int ARRAY_DIM = 4,
    parameter int KW        = 8
);
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 done;
    logic                 acc_clr;
    logic [KW-1:0]        rd_addr;
    logic [ARRAY_DIM-1:0] row_en;

    modport master (
        output start,
        output k_len,
        input  busy,
        input  done,
        input  acc_clr,
        input  rd_addr,
        input  row_en
    );

    modport slave (
        input  start,
        input  k_len,
        output busy,
        output done,
        output acc_clr,
        output rd_addr,
        output row_en
    );

endinterface

// File: rtl/skew_shift.sv
// Triangular skew line: tap s is the input delayed by s+1 cycles.
// Used to stagger per-row feed enables behind row 0.
module skew_shift #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_din,
    output logic [STAGES-1:0] o_taps
);

    logic [STAGES-1:0] r_taps;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_taps <= '0;
        end else begin
            r_taps[0] <= i_din;
            for (int s = 1; s < STAGES; s++) begin
                r_taps[s] <= r_taps[s-1];
            end
        end
    end

    assign o_taps = r_taps;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one matrix-multiply pass: K operand reads with skewed row enables,
// array drain, accumulator clear at pass start and a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; k_len latched on acceptance
//   FEED  | k_reg cycles of reads, rd_addr 0..k_reg-1, row 0 enabled
//   DRAIN | 2*ARRAY_DIM-1 cycles letting the skew line and array empty
//   DONE  | single cycle, done pulse, back to IDLE
module systolic_feed_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int ARRAY_DIM = 4,
    parameter int KW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feed_ctrl_if.slave  bus
);

    localparam int DCW = drain_cnt_w(ARRAY_DIM);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(drain_len(ARRAY_DIM) - 1);

    feed_state_e           r_state;
    feed_state_e           w_state_nxt;
    logic [KW-1:0]         r_k_reg;
    logic [KW-1:0]         w_k_nxt;
    logic [KW-1:0]         r_feed_cnt;
    logic [KW-1:0]         w_feed_cnt_nxt;
    logic [DCW-1:0]        r_drain_cnt;
    logic [DCW-1:0]        w_drain_cnt_nxt;
    logic                  w_accept;
    logic                  r_feed_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_acc_clr;
    logic [ARRAY_DIM-1:1]  w_row_tail;

    // Feed counter doubles as rd_addr; it is held at zero outside FEED.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k_reg;
        w_feed_cnt_nxt  = '0;
        w_drain_cnt_nxt = r_drain_cnt;
        w_accept        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_k_nxt     = bus.k_len;
                    w_state_nxt = (bus.k_len != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (r_feed_cnt == (r_k_reg - KW'(1))) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                end else begin
                    w_feed_cnt_nxt = r_feed_cnt + KW'(1);
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DCW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k_reg      <= '0;
            r_feed_cnt   <= '0;
            r_drain_cnt  <= '0;
            r_feed_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_acc_clr    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k_reg      <= w_k_nxt;
            r_feed_cnt   <= w_feed_cnt_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_feed_valid <= (w_state_nxt == FEED);
            r_busy       <= (w_state_nxt != IDLE);
            r_done       <= (w_state_nxt == DONE);
            r_acc_clr    <= w_accept;
        end
    end

    skew_shift #(
        .STAGES (ARRAY_DIM - 1)
    ) u_skew (
        .clk    (clk),
        .i_clr  (rst),
        .i_din  (r_feed_valid),
        .o_taps (w_row_tail)
    );

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.acc_clr = r_acc_clr;
    assign bus.rd_addr = r_feed_cnt;
    assign bus.row_en  = {w_row_tail, r_feed_valid};

endmodule
